// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receiver
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_t;

    localparam int DATA_W_DEFAULT = 24;

    // bit_cnt must hold DATA_W itself so it can saturate there
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - synchronizer chain with rising-edge pulse output
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              q_prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            chain  <= '0;
            q_prev <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], d};
            q_prev <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~q_prev;

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S serial receiver delivering left/right frames
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int               CNT_W   = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    logic [1:0]             rst_pipe;
    logic                   rst_sync;
    logic [SYNC_STAGES-1:0] lr_chain;
    logic [SYNC_STAGES-1:0] sd_chain;
    logic                   lr_s;
    logic                   sd_s;
    logic                   bclk_rise;
    logic                   lr_prev;
    logic                   lr_edge;
    i2s_state_t             state;
    i2s_state_t             state_next;
    logic                   fin_left;
    logic                   fin_right;
    logic                   shift_en;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      chan_sr;
    logic [DATA_W-1:0]      ch_next;
    logic [DATA_W-1:0]      left_hold;
    logic                   left_ok;
    logic                   frame_done;

    // Asserts immediately, releases two clk_in edges after reset drops
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end
    assign rst_sync = rst_pipe[1];

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk_in (clk_in),
        .reset  (rst_sync),
        .d      (bclk),
        .rise   (bclk_rise)
    );

    always_ff @(posedge clk_in or posedge rst_sync) begin
        if (rst_sync) begin
            lr_chain <= '0;
            sd_chain <= '0;
        end else begin
            lr_chain <= {lr_chain[SYNC_STAGES-2:0], lrclk};
            sd_chain <= {sd_chain[SYNC_STAGES-2:0], sdin};
        end
    end
    assign lr_s = lr_chain[SYNC_STAGES-1];
    assign sd_s = sd_chain[SYNC_STAGES-1];

    assign lr_edge = bclk_rise & (lr_s ^ lr_prev);

    always_ff @(posedge clk_in or posedge rst_sync) begin
        if (rst_sync) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (lr_edge) begin
            state_next = lr_s ? ST_RIGHT : ST_LEFT;
        end
    end

    always_comb begin
        fin_left  = lr_edge && (state == ST_LEFT);
        fin_right = lr_edge && (state == ST_RIGHT);
        shift_en  = bclk_rise && !lr_edge && (state != ST_SYNC);
    end

    // Current channel with this rise's bit placed in its MSB-first slot
    always_comb begin
        ch_next = chan_sr;
        for (int i = 0; i < DATA_W; i++) begin
            if ((bit_cnt < CNT_MAX) && (i == DATA_W - 1 - int'(bit_cnt))) begin
                ch_next[i] = sd_s;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_sync) begin
        if (rst_sync) begin
            lr_prev   <= 1'b0;
            bit_cnt   <= '0;
            chan_sr   <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
        end else begin
            if (bclk_rise) begin
                lr_prev <= lr_s;
            end
            if (lr_edge) begin
                bit_cnt <= '0;
                chan_sr <= '0;
            end else if (shift_en && (bit_cnt < CNT_MAX)) begin
                chan_sr <= ch_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (fin_left) begin
                left_hold <= ch_next;
                left_ok   <= 1'b1;
            end else if (fin_right) begin
                left_ok   <= 1'b0;
            end
        end
    end

    assign frame_done = fin_right & left_ok;

    // Held frame is only replaced when empty or being transferred this cycle
    always_ff @(posedge clk_in or posedge rst_sync) begin
        if (rst_sync) begin
            left_data   <= '0;
            right_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (frame_done && (!frame_valid || frame_ready)) begin
                left_data   <= left_hold;
                right_data  <= ch_next;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (frame_done && frame_valid && !frame_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter: DATA_W, default 24, sample width per channel in bits (range 8..32).
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer flops per asynchronous input (range 2..3).
REQ-003 clk_in  input  1  system clock, 50 MHz nominal.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 bclk  input  1  external I2S bit clock, asynchronous to clk_in.
REQ-006 lrclk  input  1  external I2S word select: 0 = left, 1 = right.
REQ-007 sdin  input  1  I2S serial data, MSB first.
REQ-008 left_data  output  DATA_W  left sample of the held frame.
REQ-009 right_data  output  DATA_W  right sample of the held frame.
REQ-010 frame_valid  output  1  frame held and awaiting transfer.
REQ-011 frame_ready  input  1  consumer accepts the frame.
REQ-012 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-013 overrun_clr  input  1  single-cycle pulse that clears overrun.

Function
REQ-020 bclk, lrclk and sdin SHALL pass through SYNC_STAGES flops into the clk_in domain.
REQ-021 A bclk rising event SHALL be a one-clk_in-cycle pulse when the synchronized bclk changes from 0 to 1.
REQ-022 sdin and lrclk SHALL be sampled only on bclk rising events.
REQ-023 The block SHALL support clk_in ≥ 8× bclk; behaviour below this ratio is undefined.
REQ-024 The FSM SHALL have the states SYNC, LEFT and RIGHT.
REQ-025 SYNC is entered on reset; bits are discarded until the first sampled lrclk change.
REQ-026 On a rise where sampled lrclk differs from its previous sample, the sdin bit SHALL go to the outgoing channel. This is the I2S one-bit delay: the bit is the LSB slot of the outgoing channel.
REQ-027 On that same rise the outgoing channel SHALL be finalized, bit_cnt SHALL reset to 0, and the state SHALL move to LEFT (lrclk=0) or RIGHT (lrclk=1).
REQ-028 On other rises in LEFT/RIGHT, the bit SHALL shift MSB-first into the channel register while bit_cnt < DATA_W; bit_cnt SHALL saturate at DATA_W.
REQ-029 Bits beyond DATA_W SHALL be ignored.
REQ-030 A channel with fewer than DATA_W bits SHALL be left-aligned and zero-padded in the LSBs.
REQ-031 A frame SHALL complete when RIGHT is finalized and a LEFT started by an lrclk edge preceded it in the same frame. A RIGHT entered directly from SYNC SHALL produce no frame.
REQ-032 Frame load timing: left_data/right_data SHALL update and frame_valid SHALL assert on the clk_in cycle after the finalizing bclk rise event.
REQ-033 Transfer SHALL occur on a cycle with frame_valid=1 and frame_ready=1; frame_valid SHALL deassert on the next cycle unless a new frame loads.
REQ-034 If a frame completes while frame_valid=1 and frame_ready=0, the new frame SHALL be dropped, held data SHALL be unchanged, and overrun SHALL set.
REQ-035 If completion and transfer coincide, the new frame SHALL load, frame_valid SHALL stay 1, and overrun SHALL not set.
REQ-036 When overrun_clr and an overrun event coincide, overrun SHALL remain 1.
REQ-037 left_data/right_data SHALL be stable while frame_valid=1.

Reset
REQ-040 Reset SHALL be asynchronous assert and synchronous deassert, relative to clk_in.
REQ-041 Reset values: state=SYNC, bit_cnt=0, synchronizers=0, left_data=0, right_data=0, frame_valid=0, overrun=0.
REQ-042 Reset mid-frame SHALL discard partial data; the next frame is emitted only after a full LEFT then RIGHT sequence.

Structure
REQ-050 Shared package i2s_pkg SHALL hold the FSM state enum, the DATA_W default, and the bit_cnt width, computed as clog2(DATA_W+1).
REQ-051 Sub-module i2s_sync_edge SHALL implement one synchronizer plus rise detect. It is instantiated for bclk; lrclk and sdin use the synchronizer only.
REQ-052 RTL SHALL contain no logic clocked by bclk; clk_in is the only clock.

Verification
REQ-060 Scenario: 48 bclk/frame, left=0xABCDEF, right=0x123456, frame_ready=1 -> one frame_valid pulse per frame with exact data; the first partial frame after reset is discarded.
REQ-061 Scenario: 32-bit slots with DATA_W=24, left=0xA5A5A5FF -> left_data=0xA5A5A5; extra bits ignored.
REQ-062 Scenario: 16-bit slots with DATA_W=24, left=0x8001 -> left_data=0x800100.
REQ-063 Scenario: frame_ready=0 for two frames -> first frame held, second dropped, overrun=1; after overrun_clr pulse -> overrun=0.
REQ-064 Scenario: reset asserted at bit 10 of LEFT -> outputs return to reset values; no frame until the next complete LEFT+RIGHT.
REQ-065 Scenario: frame_ready toggled on the completion cycle -> frame_valid stays 1, new data loads, overrun=0.
